// File: rtl/apb_master_arb_if.sv
// APB bus between the two-requester arbitrating master and a single slave.
interface apb_master_arb_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master with a per-transfer wait-state timeout.
module apb_master_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [63:0]      addr,
    input  logic [15:0]      wdata,
    output logic [1:0]       done,
    output logic [7:0]       rdata,
    output logic             err,
    apb_master_arb_if.master apb
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             lp_q, lp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [31:0]      paddr_q, paddr_d;
    logic             pwrite_q, pwrite_d;
    logic [7:0]       pwdata_q, pwdata_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic [1:0]       done_q, done_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [1:0]       elig_c;
    logic             win_c;

    // A requester being acknowledged this cycle sits out; ties go away from the last owner.
    assign elig_c    = req & ~done_q;
    assign win_c     = (elig_c == 2'b11) ? ~lp_q : elig_c[1];
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next-state, grant latching, completion and timeout logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lp_d      = lp_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        done_d    = 2'b00;
        rdata_d   = 8'h00;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|elig_c) begin
                    owner_d  = win_c;
                    pwrite_d = we[win_c];
                    paddr_d  = win_c ? addr[63:32] : addr[31:0];
                    pwdata_d = win_c ? wdata[15:8] : wdata[7:0];
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    state_d = IDLE;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    err_d   = apb.pslverr;
                    rdata_d = pwrite_q ? 8'h00 : apb.prdata;
                    lp_d    = owner_q;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_LAST) begin
                        state_d = IDLE;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                        err_d   = 1'b1;
                        lp_d    = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            lp_q      <= 1'b1;
            cnt_q     <= '0;
            paddr_q   <= 32'h0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 8'h00;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 2'b00;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lp_q      <= lp_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign err         = err_q;

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum ACCESS-phase cycles with pready=0 before the transfer is aborted (legal range 2..255).
REQ-002 SHALL have port pclk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port presetn, input, 1: reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 2: req[i] is the transfer request from requester i, held high until done[i].
REQ-005 SHALL have port we, input, 2: we[i]=1 write, 0 read, for requester i.
REQ-006 SHALL have port addr, input, 64: addr[32*i+:32] is the target address of requester i.
REQ-007 SHALL have port wdata, input, 16: wdata[8*i+:8] is the write data of requester i.
REQ-008 SHALL have port done, output, 2: one-cycle completion pulse to requester i.
REQ-009 SHALL have port rdata, output, 8: read data, valid only while any done bit is high.
REQ-010 SHALL have port err, output, 1: completion error flag, valid only while any done bit is high.
REQ-011 SHALL have port paddr, output, 32: APB address.
REQ-012 SHALL have port psel, output, 1: APB select.
REQ-013 SHALL have port penable, output, 1: APB enable.
REQ-014 SHALL have port pwrite, output, 1: APB direction.
REQ-015 SHALL have port pwdata, output, 8: APB write data.
REQ-016 SHALL have port prdata, input, 8: APB read data.
REQ-017 SHALL have port pready, input, 1: APB ready.
REQ-018 SHALL have port pslverr, input, 1: APB slave error.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-020 IDLE: if any unmasked req is high, SHALL grant one, latch its we/addr/wdata into pwrite/paddr/pwdata, record owner, go to SETUP.
REQ-021 Arbitration SHALL be round-robin: single requester wins outright; if both request, the one not equal to last-owner pointer lp wins.
REQ-022 In IDLE, any requester whose done bit is high in that cycle SHALL be masked from arbitration.
REQ-023 SETUP: psel=1, penable=0, exactly one cycle, then go to ACCESS.
REQ-024 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL remain stable from SETUP through the end of ACCESS.
REQ-025 ACCESS with pready=1: go to IDLE; next cycle done[owner]=1, err=pslverr, rdata=prdata for reads and 0x00 for writes; lp<=owner.
REQ-026 Wait counter SHALL count ACCESS cycles with pready=0; when it reaches TIMEOUT, abort: go to IDLE, done[owner]=1, err=1, rdata=0x00, lp<=owner.
REQ-027 Wait counter SHALL clear on entry to SETUP.
REQ-028 psel and penable SHALL be 0 in IDLE; paddr/pwrite/pwdata SHALL hold their last values in IDLE.
REQ-029 Latency SHALL be as follows, with req sampled in IDLE at cycle 0 and zero-wait slave: psel=1 in cycle 1, penable=1 in cycle 2, done in cycle 3.
REQ-030 Input changes after grant SHALL be ignored; a req dropped mid-transfer SHALL NOT cancel the transfer, and done still pulses.
REQ-031 done SHALL be one-hot or zero, never high for more than one cycle per transfer; rdata and err SHALL be 0 when done=0.
REQ-032 At least one IDLE cycle SHALL separate consecutive transfers.

Reset
REQ-033 presetn=0 SHALL asynchronously force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, done=0, rdata=0, err=0, counter=0, lp=1.
REQ-034 Reset during SETUP or ACCESS SHALL abandon the transfer with no done pulse; after release, pending reqs arbitrate afresh with requester 0 winning a tie.

Verification
REQ-035 Req0 write addr=3 wdata=0xA5, zero-wait slave -> psel cycle 1, penable cycle 2, done[0] cycle 3, err=0; then req0 read addr=3 -> rdata=0xA5.
REQ-036 Req0 and req1 asserted together after reset, both held -> grants alternate 0,1,0,1 over four transfers; each done pulses once.
REQ-037 Req1 read addr=20 to a 16-entry slave -> done[1]=1 with err=1, rdata=0x00.
REQ-038 Slave holds pready=0, TIMEOUT=16 -> abort after 16 ACCESS cycles: done=1, err=1, psel=0 on the following cycle.
REQ-039 Slave inserts 3 wait states -> paddr/pwdata/pwrite stable for all 3 waits; done one cycle after pready=1.
REQ-040 presetn pulsed low during ACCESS -> psel/penable drop immediately, no done; transfer re-issues after release if req is still held.
